// File: rtl/prime_pkg.sv
// Shared constants and helpers for the prime result buffer slice.
package prime_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned MIN_PRIME  = 2;

  // Bits needed to index v entries (v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/prime_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible combinationally.
module prime_fifo
  import prime_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign dout   = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; a cleared FIFO is simply empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prime_result_buffer.sv
// Buffers qualified primes from the checker and keeps running statistics.
module prime_result_buffer
  import prime_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_num,
  input  logic              in_is_prime,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_num,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  prime_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [DATA_W-1:0] max_prime,
  output logic              bad_verdict
);

  logic claimed;
  logic qualified;
  logic bad_sample;
  logic pop;
  logic push;
  logic drop;

  assign claimed    = in_valid && in_is_prime;
  assign qualified  = claimed && (in_num >= DATA_W'(MIN_PRIME));
  assign bad_sample = claimed && (in_num <  DATA_W'(MIN_PRIME));
  assign pop        = out_valid && out_ready;
  assign push       = qualified && (!full || pop);
  assign drop       = qualified && full && !pop;
  assign out_valid  = !empty;

  prime_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .din   (in_num),
    .pop   (pop),
    .dout  (out_num),
    .full  (full),
    .empty (empty)
  );

  // Statistics; counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_count <= '0;
      drop_count  <= '0;
      max_prime   <= '0;
      bad_verdict <= 1'b0;
    end else if (clear) begin
      prime_count <= '0;
      drop_count  <= '0;
      max_prime   <= '0;
      bad_verdict <= 1'b0;
    end else begin
      if (qualified && (prime_count != '1)) prime_count <= prime_count + CNT_W'(1);
      if (drop && (drop_count != '1))       drop_count  <= drop_count + CNT_W'(1);
      if (qualified && (in_num > max_prime)) max_prime  <= in_num;
      if (bad_sample)                        bad_verdict <= 1'b1;
    end
  end

endmodule
